// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage core datapath and pipe_hazard_ctrl.
// The slave modport is the controller; the master side drives the stall and event inputs.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             imem_ready_i;
  logic             load_use_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             mdu_start_i;
  logic             mdu_done_i;
  logic             redirect_i;
  logic             trap_i;
  logic             halt_req_i;
  logic             resume_i;
  logic             pc_en_o;
  logic             en_ifid_o;
  logic             clr_ifid_o;
  logic             en_idex_o;
  logic             clr_idex_o;
  logic             en_exmem_o;
  logic             clr_exmem_o;
  logic             en_memwb_o;
  logic             clr_memwb_o;
  logic             mdu_kill_o;
  logic             halted_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport master (
    output imem_ready_i, load_use_i, dmem_req_i, dmem_ack_i, mdu_start_i,
           mdu_done_i, redirect_i, trap_i, halt_req_i, resume_i,
    input  pc_en_o, en_ifid_o, clr_ifid_o, en_idex_o, clr_idex_o,
           en_exmem_o, clr_exmem_o, en_memwb_o, clr_memwb_o,
           mdu_kill_o, halted_o, stall_cycles_o
  );

  modport slave (
    input  imem_ready_i, load_use_i, dmem_req_i, dmem_ack_i, mdu_start_i,
           mdu_done_i, redirect_i, trap_i, halt_req_i, resume_i,
    output pc_en_o, en_ifid_o, clr_ifid_o, en_idex_o, clr_idex_o,
           en_exmem_o, clr_exmem_o, en_memwb_o, clr_memwb_o,
           mdu_kill_o, halted_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: per-bank enable/clear, PC enable,
// multicycle-unit tracking, debug halt/drain FSM and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int DW = $clog2(DRAIN_CYC + 2);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t           r_state, w_next;
  logic             r_mdu_busy;
  logic             r_halted;
  logic [DW-1:0]    r_drain_cnt, w_drain_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_mem_stall, w_ex_stall, w_force_pc;
  logic       w_pc, w_kill;
  logic [3:0] w_en, w_clr; // bit 0 IF/ID, 1 ID/EX, 2 EX/MEM, 3 MEM/WB

  assign w_mem_stall = hz.dmem_req_i & ~hz.dmem_ack_i;
  assign w_ex_stall  = (hz.mdu_start_i | r_mdu_busy) & ~hz.mdu_done_i;
  assign w_force_pc  = hz.trap_i | (hz.redirect_i & ~w_mem_stall & ~w_ex_stall);

  always_comb begin
    w_pc        = 1'b1;
    w_en        = 4'b1111;
    w_clr       = 4'b0000;
    w_kill      = 1'b0;
    w_next      = r_state;
    w_drain_nxt = r_drain_cnt;

    if (hz.trap_i) begin
      w_clr  = 4'b1111;
      w_kill = r_mdu_busy;
    end else if (w_mem_stall) begin
      w_pc  = 1'b0;
      w_en  = 4'b1000;
      w_clr = 4'b1000;
    end else if (w_ex_stall) begin
      w_pc  = 1'b0;
      w_en  = 4'b1100;
      w_clr = 4'b0100;
    end else if (hz.redirect_i) begin
      w_clr = 4'b0011;
    end else if (hz.load_use_i) begin
      w_pc  = 1'b0;
      w_en  = 4'b1110;
      w_clr = 4'b0010;
    end else if (!hz.imem_ready_i) begin
      w_pc  = 1'b0;
      w_clr = 4'b0001;
    end

    case (r_state)
      S_RUN: begin
        if (hz.halt_req_i) begin
          w_next      = S_DRAIN;
          w_drain_nxt = DW'(DRAIN_CYC);
        end
      end
      S_DRAIN: begin
        // Fetch is stopped; an advancing IF/ID takes a bubble instead of a new instruction.
        if (!w_force_pc) begin
          w_pc = 1'b0;
          if (w_en[0]) w_clr[0] = 1'b1;
        end
        if (!w_mem_stall && !w_ex_stall) begin
          if (r_drain_cnt <= DW'(1)) begin
            w_next      = S_HALTED;
            w_drain_nxt = '0;
          end else begin
            w_drain_nxt = r_drain_cnt - DW'(1);
          end
        end
      end
      S_HALTED: begin
        w_pc   = 1'b0;
        w_en   = 4'b0000;
        w_clr  = 4'b0000;
        w_kill = 1'b0;
        if (hz.resume_i) w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
      r_mdu_busy  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_drain_cnt <= w_drain_nxt;
      r_halted    <= (w_next == S_HALTED);
      if (hz.trap_i || hz.mdu_done_i)
        r_mdu_busy <= 1'b0;
      else if (hz.mdu_start_i)
        r_mdu_busy <= 1'b1;
      if ((r_state == S_RUN) && !w_pc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Controls are forced low for as long as reset is asserted, independent of the clock.
  assign hz.pc_en_o        = w_pc    & reset;
  assign hz.en_ifid_o      = w_en[0] & reset;
  assign hz.clr_ifid_o     = w_clr[0] & reset;
  assign hz.en_idex_o      = w_en[1] & reset;
  assign hz.clr_idex_o     = w_clr[1] & reset;
  assign hz.en_exmem_o     = w_en[2] & reset;
  assign hz.clr_exmem_o    = w_clr[2] & reset;
  assign hz.en_memwb_o     = w_en[3] & reset;
  assign hz.clr_memwb_o    = w_clr[3] & reset;
  assign hz.mdu_kill_o     = w_kill  & reset;
  assign hz.halted_o       = r_halted;
  assign hz.stall_cycles_o = r_stall_cnt;
endmodule
